// File: rtl/labfinalsoc_nios2_gen2_0_cpu_ocimem_ctrl.sv
// Debug on-chip memory controller: JTAG monitor reads/writes and a CPU Avalon-MM slave
// share one private single-port RAM, with JTAG commands taking priority over the CPU.
module labfinalsoc_nios2_gen2_0_cpu_ocimem_ctrl #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic              cpu_debugaccess,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    JRD,
    JCAP,
    CRD,
    CCAP
  } state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   mon_a_reg, mon_a_d;
  logic [DATA_W-1:0]   mon_d_d;
  logic                ready_d;
  logic                error_d;

  logic                ram_we;
  logic [IDX_W-1:0]    ram_wa;
  logic [DATA_W-1:0]   ram_wd;
  logic                ram_re;
  logic [IDX_W-1:0]    ram_ra;
  logic                ram_oor;
  logic [DATA_W-1:0]   ram_q;

  logic                any_take;
  logic                mon_oor;
  logic                cpu_oor;
  logic                unused_jdo;

  function automatic logic is_oor(input logic [ADDR_W-1:0] a);
    return 32'(a) >= DEPTH;
  endfunction

  assign any_take     = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign mon_oor      = is_oor(mon_a_reg);
  assign cpu_oor      = is_oor(cpu_address);
  assign cpu_readdata = ram_q;
  assign unused_jdo   = ^{jdo[37:35], jdo[2:0]};

  // Storage powers up as zero; XOR-encoding with INIT_VAL makes unwritten words read as INIT_VAL.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_wa] <= ram_wd ^ INIT_VAL;
    end
  end

  // Registered RAM read port; an out-of-range address reads as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_q <= '0;
    end else if (ram_re) begin
      ram_q <= ram_oor ? '0 : (mem[ram_ra] ^ INIT_VAL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mon_a_reg     <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      mon_a_reg     <= mon_a_d;
      MonDReg       <= mon_d_d;
      monitor_ready <= ready_d;
      monitor_error <= error_d;
    end
  end

  always_comb begin
    state_d         = state;
    mon_a_d         = mon_a_reg;
    mon_d_d         = MonDReg;
    ready_d         = monitor_ready;
    error_d         = monitor_error;
    ram_we          = 1'b0;
    ram_wa          = IDX_W'(mon_a_reg);
    ram_wd          = jdo[34:3];
    ram_re          = 1'b0;
    ram_ra          = IDX_W'(mon_a_reg);
    ram_oor         = mon_oor;
    cpu_waitrequest = cpu_read | cpu_write;

    case (state)
      IDLE: begin
        if (any_take) begin
          ready_d = 1'b0;
          if (take_action_ocimem_a) begin
            error_d = 1'b0;
            mon_a_d = ADDR_W'(jdo[33:26]);
            if (jdo[17]) begin
              state_d = JRD;
            end else begin
              ready_d = 1'b1;
            end
          end else if (take_no_action_ocimem_a) begin
            mon_a_d = mon_a_reg + ADDR_W'(1);
            state_d = JRD;
          end else begin
            if (mon_oor) begin
              error_d = 1'b1;
            end else begin
              ram_we = 1'b1;
            end
            mon_a_d = mon_a_reg + ADDR_W'(1);
            ready_d = 1'b1;
          end
        end else if (cpu_write) begin
          cpu_waitrequest = 1'b0;
          if (cpu_debugaccess && !cpu_oor) begin
            ram_we = 1'b1;
            ram_wa = IDX_W'(cpu_address);
            ram_wd = cpu_writedata;
          end
        end else if (cpu_read) begin
          state_d = CRD;
        end
      end
      JRD: begin
        ram_re  = 1'b1;
        state_d = JCAP;
      end
      JCAP: begin
        mon_d_d = ram_q;
        ready_d = 1'b1;
        error_d = monitor_error | mon_oor;
        state_d = IDLE;
      end
      CRD: begin
        ram_re  = 1'b1;
        ram_ra  = IDX_W'(cpu_address);
        ram_oor = cpu_oor;
        state_d = CCAP;
      end
      CCAP: begin
        cpu_waitrequest = 1'b0;
        state_d         = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A command arriving while busy is an overrun: dropped and flagged.
    if ((state != IDLE) && any_take) begin
      error_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_labfinalsoc_nios2_gen2_0_cpu_ocimem_ctrl.sv
// Scoreboard bench for the debug on-chip memory controller; a second instance with
// DEPTH=128 shares all inputs so out-of-range behaviour can be observed.
module tb_labfinalsoc_nios2_gen2_0_cpu_ocimem_ctrl;

  localparam int K_A  = 0;
  localparam int K_NA = 1;
  localparam int K_B  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_a, take_na, take_b;
  logic [7:0]  cpu_address;
  logic        cpu_read, cpu_write, cpu_debugaccess;
  logic [31:0] cpu_writedata;

  logic [31:0] MonDReg, cpu_readdata;
  logic        monitor_ready, monitor_error, cpu_waitrequest;
  logic [31:0] s_MonDReg, s_cpu_readdata;
  logic        s_monitor_ready, s_monitor_error, s_cpu_waitrequest;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } jexp_t;

  jexp_t       jq[$];
  logic [31:0] cq[$];
  int          checks = 0;
  int          errors = 0;
  logic        prev_rdy = 1'b0;

  always #5 clk = ~clk;

  labfinalsoc_nios2_gen2_0_cpu_ocimem_ctrl #(.ADDR_W(8), .DEPTH(256), .INIT_VAL(32'h0)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_a), .take_no_action_ocimem_a(take_na), .take_action_ocimem_b(take_b),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_debugaccess(cpu_debugaccess),
    .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest)
  );

  labfinalsoc_nios2_gen2_0_cpu_ocimem_ctrl #(.ADDR_W(8), .DEPTH(128), .INIT_VAL(32'h0)) dut_s (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_a), .take_no_action_ocimem_a(take_na), .take_action_ocimem_b(take_b),
    .MonDReg(s_MonDReg), .monitor_ready(s_monitor_ready), .monitor_error(s_monitor_error),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_debugaccess(cpu_debugaccess),
    .cpu_readdata(s_cpu_readdata), .cpu_waitrequest(s_cpu_waitrequest)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd);
    logic [37:0] j;
    j        = '0;
    j[33:26] = addr;
    j[17]    = rd;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [37:0] j;
    j       = '0;
    j[34:3] = data;
    return j;
  endfunction

  // Monitor: JTAG completion on monitor_ready rising, CPU read completion on waitrequest low.
  always @(negedge clk) begin : monitor
    jexp_t       x;
    logic [31:0] cx;
    if (monitor_ready && !prev_rdy) begin
      if (jq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL jtag_unexpected: got MonDReg 0x%08h with no expected entry", MonDReg);
      end else begin
        x = jq.pop_front();
        check("jtag_MonDReg", MonDReg, x.data);
        check("jtag_error", 32'(monitor_error), 32'(x.err));
      end
    end
    prev_rdy = monitor_ready;
    if (cpu_read && !cpu_waitrequest) begin
      if (cq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cpu_unexpected: got readdata 0x%08h with no expected entry", cpu_readdata);
      end else begin
        cx = cq.pop_front();
        check("cpu_readdata", cpu_readdata, cx);
      end
    end
  end

  task automatic pulse(input int kind, input logic [37:0] j);
    @(posedge clk); #1;
    jdo = j;
    case (kind)
      K_A:     take_a  = 1'b1;
      K_NA:    take_na = 1'b1;
      default: take_b  = 1'b1;
    endcase
    @(posedge clk); #1;
    take_a  = 1'b0;
    take_na = 1'b0;
    take_b  = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!monitor_ready && n < 12);
    check({name, "_ready"}, 32'(monitor_ready), 32'd1);
    check({name, "_latency"}, 32'(n), 32'd3);
  endtask

  task automatic jtag_read(input logic [7:0] addr, input logic [31:0] d, input logic e, input string name);
    jq.push_back(jexp_t'{data: d, err: e});
    pulse(K_A, jdo_a(addr, 1'b1));
    wait_ready(name);
  endtask

  task automatic jtag_next(input logic [31:0] d, input logic e, input string name);
    jq.push_back(jexp_t'{data: d, err: e});
    pulse(K_NA, jdo_a(8'h00, 1'b0));
    wait_ready(name);
  endtask

  task automatic jtag_load(input logic [7:0] addr);
    pulse(K_A, jdo_a(addr, 1'b0));
  endtask

  task automatic jtag_write(input logic [31:0] data);
    pulse(K_B, jdo_b(data));
  endtask

  task automatic cpu_rd(input logic [7:0] a, input logic [31:0] d, input int exp_cycles, input string name);
    int n;
    n = 0;
    cq.push_back(d);
    @(posedge clk); #1;
    cpu_address = a;
    cpu_read    = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (cpu_waitrequest && n < 12);
    check({name, "_cycles"}, 32'(n), 32'(exp_cycles));
    @(posedge clk); #1;
    cpu_read = 1'b0;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input logic dbg, input string name);
    @(posedge clk); #1;
    cpu_address     = a;
    cpu_writedata   = d;
    cpu_debugaccess = dbg;
    cpu_write       = 1'b1;
    @(negedge clk);
    check({name, "_waitrequest"}, 32'(cpu_waitrequest), 32'd0);
    @(posedge clk); #1;
    cpu_write       = 1'b0;
    cpu_debugaccess = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset = 1'b1;
    jdo = '0;
    take_a = 1'b0;
    take_na = 1'b0;
    take_b = 1'b0;
    cpu_address = '0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_debugaccess = 1'b0;
    cpu_writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_MonDReg", MonDReg, 32'h0);
    check("rst_ready", 32'(monitor_ready), 32'd0);
    check("rst_error", 32'(monitor_error), 32'd0);
    check("rst_readdata", cpu_readdata, 32'h0);
    check("rst_waitrequest", 32'(cpu_waitrequest), 32'd0);
    reset = 1'b0;

    // Reset in the middle of a JTAG read, then a normal read.
    jtag_read(8'h00, 32'h0, 1'b0, "init_rd");
    jtag_load(8'h05);
    jtag_write(32'h5555_0005);
    jtag_read(8'h05, 32'h5555_0005, 1'b0, "rd5");
    pulse(K_A, jdo_a(8'h09, 1'b1));
    reset = 1'b1;
    #2;
    check("midrst_MonDReg", MonDReg, 32'h0);
    check("midrst_ready", 32'(monitor_ready), 32'd0);
    check("midrst_error", 32'(monitor_error), 32'd0);
    check("midrst_readdata", cpu_readdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    jtag_read(8'h05, 32'h5555_0005, 1'b0, "post_rst_rd");

    // Write then read back; follow-on read proves MonAReg held the read address.
    jtag_load(8'h10);
    jtag_write(32'hCAFE_F00D);
    jtag_write(32'h0000_1111);
    jtag_read(8'h10, 32'hCAFE_F00D, 1'b0, "rd10");
    jtag_next(32'h0000_1111, 1'b0, "next11");

    // Address wrap from 0xFF to 0.
    jtag_load(8'h00);
    jtag_write(32'h0BAD_BEEF);
    jtag_load(8'hFF);
    jtag_write(32'hFFFF_00FF);
    jtag_read(8'hFF, 32'hFFFF_00FF, 1'b0, "rdFF");
    jtag_next(32'h0BAD_BEEF, 1'b0, "wrap0");

    // Out-of-range on the DEPTH=128 instance; in range on the full instance.
    jtag_load(8'h90);
    jtag_write(32'h9090_9090);
    jtag_read(8'h90, 32'h9090_9090, 1'b0, "rd90");
    check("oor_MonDReg", s_MonDReg, 32'h0);
    check("oor_error", 32'(s_monitor_error), 32'd1);
    jtag_load(8'h01);
    @(negedge clk);
    check("oor_clear_error", 32'(s_monitor_error), 32'd0);
    check("oor_clear_ready", 32'(s_monitor_ready), 32'd1);

    // JTAG write collides with CPU read of the same address: CPU stalls one extra cycle.
    jtag_load(8'h03);
    fork
      cpu_rd(8'h03, 32'h1234_5678, 4, "cpu_rd_collide");
      jtag_write(32'h1234_5678);
    join

    // CPU write without debugaccess is accepted but ignored; pulse during CRD is an overrun.
    cpu_wr(8'h03, 32'hAAAA_5555, 1'b0, "cpu_wr_nodbg");
    fork
      cpu_rd(8'h03, 32'h1234_5678, 3, "cpu_rd_after_nodbg");
      begin
        @(posedge clk);
        pulse(K_NA, jdo_a(8'h00, 1'b0));
      end
    join
    check("overrun_error", 32'(monitor_error), 32'd1);
    check("overrun_ready", 32'(monitor_ready), 32'd1);
    jtag_write(32'h4444_4444);
    jtag_read(8'h04, 32'h4444_4444, 1'b0, "rd4_after_overrun");

    // CPU write with debugaccess takes effect.
    cpu_wr(8'h06, 32'h600D_600D, 1'b1, "cpu_wr_dbg");
    cpu_rd(8'h06, 32'h600D_600D, 3, "cpu_rd6");
    jtag_read(8'h06, 32'h600D_600D, 1'b0, "jtag_rd6");

    repeat (4) @(posedge clk);
    check("jq_drained", 32'(jq.size()), 32'd0);
    check("cq_drained", 32'(cq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
